// File: rtl/sc_frame_shifter.sv
// rtl/sc_frame_shifter.sv - parametrised MAROC slow-control frame serialiser
// Optional feature macro: SC_READBACK_EN (second shift pass, Q_SC_in capture and compare)
// Ports:
//   clk_in        system clock
//   reset_n_in    asynchronous active-low reset
//   start_in      transfer request, sampled only in IDLE
//   frame_in      FRAME_W-bit frame, bit 0 shifted first
//   Q_SC_in       serial return from the chip SC register tail (readback build only)
//   D_SC_out      serial data to the chip
//   RSTn_SC_out   chip SC register reset, active-low
//   CK_SC_out     serial clock to the chip
//   state_out     FSM state code (IDLE=0 SCRST=1 SHIFT=2 READBACK=3 DONE=4)
//   busy_out      high whenever the FSM is not in IDLE
//   done_out      one-cycle end-of-transfer pulse
//   match_out     readback result, valid from done_out until the next start
module sc_frame_shifter #(
  parameter int FRAME_W    = 829,
  parameter int CLK_DIV    = 1,
  parameter int RST_CYCLES = 4
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic               start_in,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               Q_SC_in,
  output logic               D_SC_out,
  output logic               RSTn_SC_out,
  output logic               CK_SC_out,
  output logic [2:0]         state_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               match_out
);

  localparam int BIT_W = $clog2(FRAME_W);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int RST_W = $clog2(RST_CYCLES) + 1;

  // Divider runs 0..2*CLK_DIV-1 per bit; CK goes high after DIV_HALF, low after DIV_LAST.
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCRST    = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_READBACK = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t             state;
  logic [FRAME_W-1:0] shadow;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [RST_W-1:0]   rst_cnt;

`ifdef SC_READBACK_EN
  logic               mismatch;
`else
  logic               unused_q_sc;
  assign unused_q_sc = Q_SC_in;
`endif

  assign state_out = state;

  // The shadow register rotates right by one per bit, so shadow[0] is always the
  // bit currently on D_SC_out and shadow[1] the next one. After FRAME_W rotations
  // it is back to the latched frame, ready for the readback pass.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state       <= ST_IDLE;
      shadow      <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      rst_cnt     <= '0;
      D_SC_out    <= 1'b0;
      RSTn_SC_out <= 1'b1;
      CK_SC_out   <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      match_out   <= 1'b0;
`ifdef SC_READBACK_EN
      mismatch    <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            shadow      <= frame_in;
            match_out   <= 1'b0;
`ifdef SC_READBACK_EN
            mismatch    <= 1'b0;
`endif
            rst_cnt     <= '0;
            RSTn_SC_out <= 1'b0;
            busy_out    <= 1'b1;
            state       <= ST_SCRST;
          end
        end

        ST_SCRST: begin
          if (rst_cnt == RST_LAST) begin
            RSTn_SC_out <= 1'b1;
            D_SC_out    <= shadow[0];
            bit_cnt     <= '0;
            div_cnt     <= '0;
            state       <= ST_SHIFT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        ST_SHIFT, ST_READBACK: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            CK_SC_out <= 1'b0;
            shadow    <= {shadow[0], shadow[FRAME_W-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef SC_READBACK_EN
              if (state == ST_SHIFT) begin
                D_SC_out <= shadow[1];
                state    <= ST_READBACK;
              end else begin
                D_SC_out  <= 1'b0;
                done_out  <= 1'b1;
                match_out <= ~mismatch;
                state     <= ST_DONE;
              end
`else
              D_SC_out <= 1'b0;
              done_out <= 1'b1;
              state    <= ST_DONE;
`endif
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              D_SC_out <= shadow[1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == DIV_HALF) begin
              CK_SC_out <= 1'b1;
`ifdef SC_READBACK_EN
              // Q_SC_in is taken before the chip shifts on this CK rise, so it
              // still holds the tail bit that corresponds to the bit on D_SC_out.
              if (state == ST_READBACK && Q_SC_in != shadow[0]) begin
                mismatch <= 1'b1;
              end
`endif
            end
          end
        end

        ST_DONE: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          D_SC_out    <= 1'b0;
          RSTn_SC_out <= 1'b1;
          CK_SC_out   <= 1'b0;
          busy_out    <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_frame_shifter.sv
// tb/tb_sc_frame_shifter.sv - scoreboard bench for sc_frame_shifter (16-bit and 829-bit instances)
module tb_sc_frame_shifter;

  // Latency in clk edges from the edge that samples start_in to the edge that
  // samples done_out high: 1 + 4 + 2*2*16 = 69, readback 1 + 4 + 4*2*16 = 133;
  // full size 1 + 4 + 2*1*829 = 1663, readback 1 + 4 + 4*1*829 = 3321.
`ifdef SC_READBACK_EN
  localparam int LAT16  = 133;
  localparam int LAT829 = 3321;
  localparam bit RB     = 1'b1;
`else
  localparam int LAT16  = 69;
  localparam int LAT829 = 1663;
  localparam bit RB     = 1'b0;
`endif

  typedef struct {
    logic [828:0] frame;
    int           done_edge;
    logic         match;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         start16 = 1'b0;
  logic [15:0]  frame16 = '0;
  logic         q16;
  logic         d16, rstn16, ck16, busy16, done16, match16;
  logic [2:0]   state16;

  logic         start829 = 1'b0;
  logic [828:0] frame829 = '0;
  logic         q829;
  logic         d829, rstn829, ck829, busy829, done829, match829;
  logic [2:0]   state829;

  sc_frame_shifter #(.FRAME_W(16), .CLK_DIV(2), .RST_CYCLES(4)) u16 (
    .clk_in(clk), .reset_n_in(rst_n), .start_in(start16), .frame_in(frame16),
    .Q_SC_in(q16), .D_SC_out(d16), .RSTn_SC_out(rstn16), .CK_SC_out(ck16),
    .state_out(state16), .busy_out(busy16), .done_out(done16), .match_out(match16)
  );

  sc_frame_shifter #(.FRAME_W(829), .CLK_DIV(1), .RST_CYCLES(4)) u829 (
    .clk_in(clk), .reset_n_in(rst_n), .start_in(start829), .frame_in(frame829),
    .Q_SC_in(q829), .D_SC_out(d829), .RSTn_SC_out(rstn829), .CK_SC_out(ck829),
    .state_out(state829), .busy_out(busy829), .done_out(done829), .match_out(match829)
  );

  // Chip models: SC register shifts D in at the top on each CK rise, tail is Q.
  logic [15:0]  sr16;
  int           rise16;
  logic         flip7 = 1'b0;
  logic [828:0] sr829;

  always @(posedge ck16 or negedge rstn16) begin
    if (!rstn16) begin
      sr16   <= '0;
      rise16 <= 0;
    end else begin
      sr16   <= {d16, sr16[15:1]};
      rise16 <= rise16 + 1;
    end
  end
  // Before rise 24 (readback bit 7) the tail holds frame bit 7; optionally corrupt it.
  assign q16 = sr16[0] ^ (flip7 && rise16 == 23);

  always @(posedge ck829 or negedge rstn829) begin
    if (!rstn829) sr829 <= '0;
    else          sr829 <= {d829, sr829[828:1]};
  end
  assign q829 = sr829[0];

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q16_exp[$];
  exp_t q829_exp[$];
  int   dones16 = 0;
  int   exp_dones16 = 0;
  int   dones829 = 0;
  int   nb16 = 0;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
    end
  endtask

  // Monitor for the 16-bit instance: collects bits on CK rises during SHIFT and
  // RSTn low time, and scores them against the queue when done_out appears.
  initial begin : mon16
    logic [15:0] cap;
    int          rl;
    logic        ckp;
    exp_t        e;
    cap = '0; rl = 0; ckp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cap = '0; nb16 = 0; rl = 0; ckp = 1'b0;
      end else begin
        if (!rstn16) rl++;
        if (ck16 && !ckp && state16 == 3'd2) begin
          if (nb16 < 16) cap[nb16] = d16;
          nb16++;
        end
        ckp = ck16;
        if (done16) begin
          dones16++;
          if (q16_exp.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done16_unexpected: got done_out=1 at edge %0d, required no pulse", cyc + 1);
          end else begin
            e = q16_exp.pop_front();
            check("bits16", 1024'(cap), 1024'(e.frame[15:0]));
            check("nbits16", 1024'(nb16), 1024'(16));
            check("rstlow16", 1024'(rl), 1024'(4));
            check("latency16_edge", 1024'(cyc + 1), 1024'(e.done_edge));
            check("match16", 1024'(match16), 1024'(e.match));
            check("state16_done", 1024'(state16), 1024'(4));
          end
          cap = '0; nb16 = 0; rl = 0;
        end
      end
    end
  end

  initial begin : mon829
    logic [828:0] cap;
    int           nb;
    logic         ckp;
    exp_t         e;
    cap = '0; nb = 0; ckp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cap = '0; nb = 0; ckp = 1'b0;
      end else begin
        if (ck829 && !ckp && state829 == 3'd2) begin
          if (nb < 829) cap[nb] = d829;
          nb++;
        end
        ckp = ck829;
        if (done829) begin
          dones829++;
          if (q829_exp.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done829_unexpected: got done_out=1 at edge %0d, required no pulse", cyc + 1);
          end else begin
            e = q829_exp.pop_front();
            check("bits829", 1024'(cap), 1024'(e.frame));
            check("nbits829", 1024'(nb), 1024'(829));
            check("latency829_edge", 1024'(cyc + 1), 1024'(e.done_edge));
            check("match829", 1024'(match829), 1024'(e.match));
          end
          cap = '0; nb = 0;
        end
      end
    end
  end

  // Drives a one-cycle start pulse; start is sampled at edge cyc+1.
  task automatic send16(input logic [15:0] f, input bit flip, input bit exp_match, input bit push);
    exp_t e;
    @(negedge clk);
    frame16 = f; flip7 = flip; start16 = 1'b1;
    if (push) begin
      e.frame = '0; e.frame[15:0] = f;
      e.done_edge = cyc + 1 + LAT16;
      e.match = exp_match;
      q16_exp.push_back(e);
      exp_dones16++;
    end
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic drain16(input int budget);
    int n;
    n = 0;
    while (q16_exp.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain16_pending", 1024'(q16_exp.size()), 1024'(0));
    q16_exp.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset16(input string tag);
    check({tag, "_D"},     1024'(d16),     1024'(0));
    check({tag, "_RSTn"},  1024'(rstn16),  1024'(1));
    check({tag, "_CK"},    1024'(ck16),    1024'(0));
    check({tag, "_state"}, 1024'(state16), 1024'(0));
    check({tag, "_busy"},  1024'(busy16),  1024'(0));
    check({tag, "_done"},  1024'(done16),  1024'(0));
    check({tag, "_match"}, 1024'(match16), 1024'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   n;
    int   s_edge;
    exp_t e;
    logic [828:0] big;

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset16("reset");
    check("reset_state829", 1024'(state829), 1024'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single transfer, clean readback.
    send16(16'hA5C3, 1'b0, RB, 1'b1);
    drain16(400);

    // Readback with corrupted bit 7: match must be 0.
    send16(16'h5A3C, 1'b1, 1'b0, 1'b1);
    drain16(400);
    flip7 = 1'b0;

    // Start pulse and frame change during SHIFT must be ignored.
    send16(16'h3C96, 1'b0, RB, 1'b1);
    n = 0;
    while (state16 != 3'd2 && n < 100) begin @(negedge clk); n++; end
    check("ignore_reach_shift", 1024'(state16), 1024'(2));
    start16 = 1'b1; frame16 = 16'hFFFF;
    @(negedge clk);
    start16 = 1'b0;
    repeat (10) @(negedge clk);
    frame16 = 16'h0000;
    drain16(400);
    repeat (150) @(negedge clk);
    check("ignore_done_count", 1024'(dones16), 1024'(exp_dones16));

    // Abort during bit 9 of SHIFT, then a normal transfer.
    send16(16'h1234, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!(state16 == 3'd2 && nb16 == 9) && n < 200) begin @(negedge clk); n++; end
    check("abort_reach_bit9", 1024'(nb16), 1024'(9));
    rst_n = 1'b0;
    #1;
    check_reset16("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send16(16'h0F0F, 1'b0, RB, 1'b1);
    drain16(400);
    check("abort_done_count", 1024'(dones16), 1024'(exp_dones16));

    // Back-to-back: start held high; second start sampled one IDLE cycle after DONE.
    @(negedge clk);
    frame16 = 16'hC001; start16 = 1'b1;
    s_edge = cyc + 1;
    e.frame = '0; e.frame[15:0] = 16'hC001; e.done_edge = s_edge + LAT16; e.match = RB;
    q16_exp.push_back(e);
    e.frame[15:0] = 16'h8E71; e.done_edge = s_edge + LAT16 + 1 + LAT16;
    q16_exp.push_back(e);
    exp_dones16 += 2;
    @(negedge clk);
    frame16 = 16'h8E71;
    n = 0;
    while (cyc < s_edge + LAT16 + 1 && n < 400) begin @(negedge clk); n++; end
    start16 = 1'b0;
    drain16(400);
    check("b2b_done_count", 1024'(dones16), 1024'(exp_dones16));

    // Full-size frame on the 829-bit instance.
    for (int i = 0; i < 829; i++) big[i] = 1'($urandom_range(0, 1));
    @(negedge clk);
    frame829 = big; start829 = 1'b1;
    e.frame = big; e.done_edge = cyc + 1 + LAT829; e.match = RB;
    q829_exp.push_back(e);
    @(negedge clk);
    start829 = 1'b0;
    frame829 = ~big;
    n = 0;
    while (q829_exp.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    check("drain829_pending", 1024'(q829_exp.size()), 1024'(0));
    check("done829_count", 1024'(dones829), 1024'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
